serial_bus_subsystem: RTL and testbench
=======================================

// Module: serial_bus_subsystem
// PURPOSE
//   Single-master serial system bus: device-side parallel request port -> master_port
//   -> bit-serial bus -> slave memory (2**SLAVE_MEM_ADDR_WIDTH x DATA_WIDTH).
//   A two-requester priority arbiter grants bus ownership.
//   Requester 1 is the internal master port; requester 2 is exposed for a future master.
// PARAMETERS
//   ADDR_WIDTH            16  device address width; only low SLAVE_MEM_ADDR_WIDTH bits used
//   DATA_WIDTH            8   data word width
//   SLAVE_MEM_ADDR_WIDTH  12  slave memory address width (4096 words)
// PORTS
//   clk     in   1           single clock, rising edge
//   rstn    in   1           reset, asynchronous, active-low
//   dwdata  in   DATA_WIDTH  write data
//   drdata  out  DATA_WIDTH  read data, valid when dready re-asserts after a read
//   daddr   in   ADDR_WIDTH  word address
//   dvalid  in   1           request valid
//   dready  out  1           port idle, accepting a request
//   dmode   in   1           0 = read, 1 = write
//   breq2   in   1           bus request from second master (tie 0 if unused)
//   bgrant2 out  1           grant to second master
//   msel    out  1           current bus owner: 0 = master 1, 1 = master 2
// BEHAVIOUR
//   Reset (rstn=0, async): dready=1, drdata=0, all grants/valids/breq=0, msel=0.
//     FSMs go to IDLE. Memory contents are not cleared.
//   Handshake: request accepted at posedge where dvalid=1 and dready=1.
//     Captures daddr[SLAVE_MEM_ADDR_WIDTH-1:0], dwdata and dmode. dready=0 from next cycle.
//     dvalid while dready=0 is ignored; holding dvalid 2 cycles yields one transaction.
//   Master FSM:
//     IDLE -> REQ     on accept; mbreq=1.
//     REQ  -> ADDR    when mbgrant=1.
//     ADDR: SLAVE_MEM_ADDR_WIDTH cycles; address LSB-first on mwdata, mvalid=1,
//       mmode=captured dmode.
//     ADDR -> WDATA   if write: DATA_WIDTH cycles, data LSB-first, mvalid=1.
//     ADDR -> RWAIT   if read: mvalid=0; shift in srdata LSB-first while svalid=1.
//     After last bit (write) or DATA_WIDTH received bits (read): drop mbreq,
//       update drdata (read only), return to IDLE with dready=1.
//   Slave FSM: IDLE -> RADDR (first mvalid) -> {WDATA | RDELAY} -> IDLE.
//     Shifts address bits while mvalid=1; mmode sampled with first address bit.
//     Write: memory[addr] written on the cycle after the last data bit,
//       no later than the cycle dready re-asserts.
//     Read: one-cycle memory read latency, then DATA_WIDTH cycles of srdata LSB-first
//       with svalid=1.
//   Arbiter: grant latency one cycle from breq.
//     IDLE grants breq1 over breq2 on simultaneous request.
//     Grant held while owner's breq=1; released the cycle after breq drops.
//     Grants mutually exclusive; msel follows owner (holds last owner when idle).
//   While breq2 owns the bus, master 1 waits in REQ with dready=0.
//   Reset mid-transaction aborts both FSMs; a partial write never commits.
//   Upper daddr bits [ADDR_WIDTH-1:SLAVE_MEM_ADDR_WIDTH] ignored (addresses alias).
//   Write latency: accept -> dready high ~ 2+SLAVE_MEM_ADDR_WIDTH+DATA_WIDTH cycles.
//   Read latency: accept -> dready high ~ 3+SLAVE_MEM_ADDR_WIDTH+DATA_WIDTH cycles.
// TESTING
//   After reset release: dready=1, drdata=0, bgrant2=0, msel=0.
//   Write daddr=16'h0ABC, dwdata=8'h5A (dvalid held 2 cycles) -> single write;
//     dready returns 1; memory[12'hABC]=8'h5A.
//   Read daddr=16'h0ABC -> after dready=1, drdata=8'h5A.
//   10 random addr/data write+read pairs (addr & 12'hFFF) -> every memory and drdata match.
//   breq2=1 held, then write request -> stays in REQ, dready=0;
//     after breq2=0, completes (msel 1->0).
//   Write 16'hF123 data 8'hC3, read 16'h0123 -> drdata=8'hC3 (upper address bits ignored).

Source files
------------

// File: rtl/serial_bus_subsystem.sv
// Single-master serial system bus: parallel request port, bit-serial master/slave link,
// 2**SLAVE_MEM_ADDR_WIDTH-word slave memory and a two-requester priority arbiter.
module serial_bus_subsystem #(
    parameter int ADDR_WIDTH           = 16,
    parameter int DATA_WIDTH           = 8,
    parameter int SLAVE_MEM_ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic                  breq2,
    output logic                  bgrant2,
    output logic                  msel,
    output logic [2:0]            dbg_mstate_o,
    output logic [2:0]            dbg_sstate_o,
    output logic [1:0]            dbg_astate_o
);
    localparam int AW   = SLAVE_MEM_ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;
    localparam int MAXW = (AW > DW) ? AW : DW;
    localparam int CW   = $clog2(MAXW) + 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);

    localparam logic [2:0] M_IDLE = 3'd0, M_REQ = 3'd1, M_ADDR = 3'd2,
                           M_WDATA = 3'd3, M_RWAIT = 3'd4;
    localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_WDATA = 3'd2,
                           S_RDELAY = 3'd3, S_RDATA = 3'd4;
    localparam logic [1:0] A_IDLE = 2'd0, A_G1 = 2'd1, A_G2 = 2'd2;

    // Handshake: a request transfers on any rising edge where dvalid and dready are both 1;
    // dready is 1 exactly while the master is idle, so dvalid during a transaction is ignored.

    logic [2:0]    mstate_q, mstate_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mdata_q, mdata_d;
    logic          mmode_q, mmode_d;
    logic [CW-1:0] mcnt_q, mcnt_d;
    logic [DW-1:0] drdata_q, drdata_d;

    logic [2:0]    sstate_q, sstate_d;
    logic [AW-1:0] saddr_q, saddr_d;
    logic [DW-1:0] sdata_q, sdata_d;
    logic          smode_q, smode_d;
    logic [CW-1:0] scnt_q, scnt_d;

    logic [1:0]    astate_q, astate_d;
    logic          msel_q, msel_d;

    logic          mbreq, mbgrant, mvalid, mwdata, svalid, srdata;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    assign mbreq   = (mstate_q != M_IDLE);
    assign mvalid  = (mstate_q == M_ADDR) || (mstate_q == M_WDATA);
    assign mwdata  = (mstate_q == M_ADDR) ? maddr_q[0] : mdata_q[0];
    assign svalid  = (sstate_q == S_RDATA);
    assign srdata  = sdata_q[0];
    assign mbgrant = (astate_q == A_G1);
    assign bgrant2 = (astate_q == A_G2);
    assign msel    = msel_q;
    assign dready  = (mstate_q == M_IDLE);
    assign drdata  = drdata_q;

    assign dbg_mstate_o = mstate_q;
    assign dbg_sstate_o = sstate_q;
    assign dbg_astate_o = astate_q;

    always_comb begin
        mstate_d = mstate_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        mmode_d  = mmode_q;
        mcnt_d   = mcnt_q;
        drdata_d = drdata_q;
        case (mstate_q)
            M_IDLE: if (dvalid) begin
                maddr_d  = daddr[AW-1:0];
                mdata_d  = dwdata;
                mmode_d  = dmode;
                mstate_d = M_REQ;
            end
            M_REQ: if (mbgrant) begin
                mcnt_d   = '0;
                mstate_d = M_ADDR;
            end
            M_ADDR: begin
                maddr_d = maddr_q >> 1;
                mcnt_d  = mcnt_q + 1'b1;
                if (mcnt_q == ADDR_LAST) begin
                    mcnt_d   = '0;
                    mstate_d = mmode_q ? M_WDATA : M_RWAIT;
                end
            end
            M_WDATA: begin
                mdata_d = mdata_q >> 1;
                mcnt_d  = mcnt_q + 1'b1;
                if (mcnt_q == DATA_LAST) mstate_d = M_IDLE;
            end
            M_RWAIT: if (svalid) begin
                mdata_d = {srdata, mdata_q[DW-1:1]};
                mcnt_d  = mcnt_q + 1'b1;
                if (mcnt_q == DATA_LAST) begin
                    drdata_d = {srdata, mdata_q[DW-1:1]};
                    mstate_d = M_IDLE;
                end
            end
            default: mstate_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mstate_q <= M_IDLE;
            maddr_q  <= '0;
            mdata_q  <= '0;
            mmode_q  <= 1'b0;
            mcnt_q   <= '0;
            drdata_q <= '0;
        end else begin
            mstate_q <= mstate_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
            mmode_q  <= mmode_d;
            mcnt_q   <= mcnt_d;
            drdata_q <= drdata_d;
        end
    end

    // The write commits on the edge that samples the last data bit, so it is visible
    // in the following cycle, which is also the first cycle dready is back high.
    always_comb begin
        sstate_d  = sstate_q;
        saddr_d   = saddr_q;
        sdata_d   = sdata_q;
        smode_d   = smode_q;
        scnt_d    = scnt_q;
        mem_we    = 1'b0;
        mem_wdata = {mwdata, sdata_q[DW-1:1]};
        case (sstate_q)
            S_IDLE: if (mvalid) begin
                saddr_d  = {mwdata, saddr_q[AW-1:1]};
                smode_d  = mmode_q;
                scnt_d   = CW'(1);
                sstate_d = S_ADDR;
            end
            S_ADDR: if (mvalid) begin
                saddr_d = {mwdata, saddr_q[AW-1:1]};
                scnt_d  = scnt_q + 1'b1;
                if (scnt_q == ADDR_LAST) begin
                    scnt_d   = '0;
                    sstate_d = smode_q ? S_WDATA : S_RDELAY;
                end
            end
            S_WDATA: if (mvalid) begin
                sdata_d = {mwdata, sdata_q[DW-1:1]};
                scnt_d  = scnt_q + 1'b1;
                if (scnt_q == DATA_LAST) begin
                    mem_we   = 1'b1;
                    sstate_d = S_IDLE;
                end
            end
            S_RDELAY: begin
                sdata_d  = mem_q[saddr_q];
                scnt_d   = '0;
                sstate_d = S_RDATA;
            end
            S_RDATA: begin
                sdata_d = sdata_q >> 1;
                scnt_d  = scnt_q + 1'b1;
                if (scnt_q == DATA_LAST) sstate_d = S_IDLE;
            end
            default: sstate_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sstate_q <= S_IDLE;
            saddr_q  <= '0;
            sdata_q  <= '0;
            smode_q  <= 1'b0;
            scnt_q   <= '0;
        end else begin
            sstate_q <= sstate_d;
            saddr_q  <= saddr_d;
            sdata_q  <= sdata_d;
            smode_q  <= smode_d;
            scnt_q   <= scnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[saddr_q] <= mem_wdata;
    end

    // Requester 1 wins ties; an owner keeps the bus until its request drops.
    always_comb begin
        astate_d = astate_q;
        msel_d   = msel_q;
        case (astate_q)
            A_IDLE: begin
                if (mbreq) begin
                    astate_d = A_G1;
                    msel_d   = 1'b0;
                end else if (breq2) begin
                    astate_d = A_G2;
                    msel_d   = 1'b1;
                end
            end
            A_G1:    if (!mbreq) astate_d = A_IDLE;
            A_G2:    if (!breq2) astate_d = A_IDLE;
            default: astate_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            astate_q <= A_IDLE;
            msel_q   <= 1'b0;
        end else begin
            astate_q <= astate_d;
            msel_q   <= msel_d;
        end
    end

endmodule

// File: tb/tb_serial_bus_subsystem.sv
// Directed and randomized bench for serial_bus_subsystem with a flat reference memory model.
module tb_serial_bus_subsystem;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int SAW = 12;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] dwdata;
    logic [DW-1:0] drdata;
    logic [AW-1:0] daddr;
    logic          dvalid;
    logic          dready;
    logic          dmode;
    logic          breq2;
    logic          bgrant2;
    logic          msel;
    logic [2:0]    dbg_mstate;
    logic [2:0]    dbg_sstate;
    logic [1:0]    dbg_astate;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int acc_cyc = 0;
    logic [DW-1:0] ref_mem [0:(1<<SAW)-1];

    serial_bus_subsystem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_MEM_ADDR_WIDTH(SAW)
    ) dut (
        .clk(clk), .rstn(rstn), .dwdata(dwdata), .drdata(drdata), .daddr(daddr),
        .dvalid(dvalid), .dready(dready), .dmode(dmode), .breq2(breq2),
        .bgrant2(bgrant2), .msel(msel), .dbg_mstate_o(dbg_mstate),
        .dbg_sstate_o(dbg_sstate), .dbg_astate_o(dbg_astate)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (dready !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge; returns at a negedge (hold=1) or just after the next posedge (hold=2).
    task automatic issue(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int hold);
        wait_ready(200);
        chk("issue_ready", {31'd0, dready}, 32'd1);
        dvalid = 1'b1;
        dmode  = mode;
        daddr  = a;
        dwdata = d;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc_cnt;
        chk("accept_dready_low", {31'd0, dready}, 32'd0);
        if (hold > 1) begin
            @(posedge clk);
            #1;
        end
        dvalid = 1'b0;
        daddr  = AW'($urandom_range(0, 65535));
        dwdata = DW'($urandom_range(0, 255));
        dmode  = 1'($urandom_range(0, 1));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        int lat;
        issue(1'b1, a, d, hold);
        ref_mem[a[SAW-1:0]] = d;
        wait_ready(200);
        if (hold > 1) @(negedge clk);
        lat = cyc_cnt - acc_cyc;
        chk("wr_done", {31'd0, dready}, 32'd1);
        chk("wr_latency_ok", {31'd0, (lat >= SAW + DW) && (lat <= SAW + DW + 4)}, 32'd1);
        chk("wr_mem", {24'd0, dut.mem_q[a[SAW-1:0]]}, {24'd0, ref_mem[a[SAW-1:0]]});
        @(negedge clk);
        chk("wr_single_txn", {31'd0, dready}, 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int lat;
        issue(1'b0, a, DW'($urandom_range(0, 255)), 1);
        wait_ready(200);
        lat = cyc_cnt - acc_cyc;
        chk("rd_done", {31'd0, dready}, 32'd1);
        chk("rd_latency_ok", {31'd0, (lat >= SAW + DW + 1) && (lat <= SAW + DW + 5)}, 32'd1);
        chk("rd_data", {24'd0, drdata}, {24'd0, ref_mem[a[SAW-1:0]]});
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rstn   = 1'b0;
        dvalid = 1'b0;
        dmode  = 1'b0;
        daddr  = '0;
        dwdata = '0;
        breq2  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dready", {31'd0, dready}, 32'd1);
        chk("rst_drdata", {24'd0, drdata}, 32'd0);
        chk("rst_bgrant2", {31'd0, bgrant2}, 32'd0);
        chk("rst_msel", {31'd0, msel}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_dready", {31'd0, dready}, 32'd1);
        chk("post_rst_drdata", {24'd0, drdata}, 32'd0);

        // Directed write with dvalid held for two cycles, then read back.
        do_write(16'h0ABC, 8'h5A, 2);
        do_read(16'h0ABC);

        for (int i = 0; i < 10; i++) begin
            a = AW'($urandom_range(0, 65535));
            d = DW'($urandom_range(0, 255));
            do_write(a, d, 1);
            do_read({4'($urandom_range(0, 15)), a[SAW-1:0]});
        end

        // Second master owns the bus; master 1 must wait.
        breq2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("b2_grant", {31'd0, bgrant2}, 32'd1);
        chk("b2_msel", {31'd0, msel}, 32'd1);
        issue(1'b1, 16'h0456, 8'hA7, 1);
        ref_mem[12'h456] = 8'hA7;
        repeat (30) @(negedge clk);
        chk("b2_wait_dready", {31'd0, dready}, 32'd0);
        chk("b2_still_grant", {31'd0, bgrant2}, 32'd1);
        breq2 = 1'b0;
        wait_ready(100);
        chk("b2_done", {31'd0, dready}, 32'd1);
        chk("b2_msel_back", {31'd0, msel}, 32'd0);
        chk("b2_mem", {24'd0, dut.mem_q[12'h456]}, 32'h0000_00A7);

        // Simultaneous requests: master 1 has priority, master 2 follows.
        issue(1'b1, 16'h0789, 8'h3C, 1);
        ref_mem[12'h789] = 8'h3C;
        breq2 = 1'b1;
        @(negedge clk);
        chk("prio_bgrant2", {31'd0, bgrant2}, 32'd0);
        chk("prio_msel", {31'd0, msel}, 32'd0);
        wait_ready(100);
        chk("prio_done", {31'd0, dready}, 32'd1);
        chk("prio_mem", {24'd0, dut.mem_q[12'h789]}, 32'h0000_003C);
        repeat (3) @(negedge clk);
        chk("prio_b2_after", {31'd0, bgrant2}, 32'd1);
        chk("prio_msel_after", {31'd0, msel}, 32'd1);
        breq2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("release_b2", {31'd0, bgrant2}, 32'd0);
        chk("msel_holds", {31'd0, msel}, 32'd1);

        // Upper address bits alias onto the same word.
        do_write(16'hF123, 8'hC3, 1);
        do_read(16'h0123);

        // Reset in the middle of a write must not commit the partial data.
        do_write(16'h0111, 8'h96, 1);
        do_read(16'h0111);
        issue(1'b1, 16'h0111, 8'h69, 1);
        repeat (17) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_dready", {31'd0, dready}, 32'd1);
        chk("mid_rst_drdata", {24'd0, drdata}, 32'd0);
        chk("mid_rst_msel", {31'd0, msel}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_mem_kept", {24'd0, dut.mem_q[12'h111]}, {24'd0, ref_mem[12'h111]});
        do_read(16'h0111);
        do_read(16'h0ABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
